preset_timer: RTL and testbench



---
 rtl/preset_timer_pkg.sv | 20 ++
 rtl/bin2bcd6.sv | 35 +++
 rtl/preset_timer.sv | 84 ++++++++
 tb/tb_preset_timer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/preset_timer_pkg.sv
// Shared constants for the phase timer: FSM encodings, phase codes and phase durations.
package preset_timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // Phase codes shared with the preset generator
    localparam logic [1:0] PHASE_E = 2'b00;
    localparam logic [1:0] PHASE_A = 2'b01;
    localparam logic [1:0] PHASE_G = 2'b10;
    localparam logic [1:0] PHASE_L = 2'b11;

    localparam logic [5:0] DUR_E = 6'd30;
    localparam logic [5:0] DUR_A = 6'd15;
    localparam logic [5:0] DUR_G = 6'd22;
    localparam logic [5:0] DUR_L = 6'd5;

endpackage

// File: rtl/bin2bcd6.sv
// 6-bit binary to two BCD digits (0..63), purely combinational compare-subtract.
module bin2bcd6 (
    input  logic [5:0] i_bin,
    output logic [2:0] o_tens,
    output logic [3:0] o_units
);

    logic [5:0] w_rem;

    always_comb begin
        o_tens = 3'd0;
        w_rem  = i_bin;
        if (i_bin >= 6'd60) begin
            o_tens = 3'd6;
            w_rem  = i_bin - 6'd60;
        end else if (i_bin >= 6'd50) begin
            o_tens = 3'd5;
            w_rem  = i_bin - 6'd50;
        end else if (i_bin >= 6'd40) begin
            o_tens = 3'd4;
            w_rem  = i_bin - 6'd40;
        end else if (i_bin >= 6'd30) begin
            o_tens = 3'd3;
            w_rem  = i_bin - 6'd30;
        end else if (i_bin >= 6'd20) begin
            o_tens = 3'd2;
            w_rem  = i_bin - 6'd20;
        end else if (i_bin >= 6'd10) begin
            o_tens = 3'd1;
            w_rem  = i_bin - 6'd10;
        end
        o_units = w_rem[3:0];
    end

endmodule

// File: rtl/preset_timer.sv
// Countdown timer: pulse loads preset, tick decrements once per second, done strobes on expiry.
// Count is registered; BCD digits are decoded combinationally from it.
module preset_timer
    import preset_timer_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse,
    input  logic [WIDTH-1:0] preset,
    input  logic             tick,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic [2:0]       tens,
    output logic [3:0]       units,
    output logic             busy,
    output logic             done
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_done;
    logic [5:0]       w_count6;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (pulse) begin
                r_count <= preset;
                if (preset != '0) begin
                    r_state <= ST_RUN;
                end else begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (hold) begin
                            r_state <= ST_HOLD;
                        end else if (tick) begin
                            // <= 1 rather than == 1 so the count can never wrap below zero
                            if (r_count <= WIDTH'(1)) begin
                                r_count <= '0;
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_count <= r_count - WIDTH'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!hold) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        r_count <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign w_count6 = 6'(r_count);

    bin2bcd6 u_bin2bcd6 (
        .i_bin   (w_count6),
        .o_tens  (tens),
        .o_units (units)
    );

    assign count = r_count;
    assign done  = r_done;
    assign busy  = (r_state == ST_RUN) || (r_state == ST_HOLD);

endmodule

// File: tb/tb_preset_timer.sv
// Directed bench for preset_timer with hand-computed expectations.
module tb_preset_timer;

    logic       clk;
    logic       reset;
    logic       pulse;
    logic [5:0] preset;
    logic       tick;
    logic       hold;
    logic [5:0] count;
    logic [2:0] tens;
    logic [3:0] units;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;

    preset_timer #(.WIDTH(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .pulse  (pulse),
        .preset (preset),
        .tick   (tick),
        .hold   (hold),
        .count  (count),
        .tens   (tens),
        .units  (units),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_load(input logic [5:0] val);
        preset = val;
        pulse  = 1'b1;
        step();
        pulse  = 1'b0;
    endtask

    initial begin
        int done_cycles;
        int hold_bad;
        reset  = 1'b1;
        pulse  = 1'b0;
        preset = 6'd0;
        tick   = 1'b0;
        hold   = 1'b0;
        #12;
        chk("rst_count", count, 0);
        chk("rst_tens",  tens,  0);
        chk("rst_units", units, 0);
        chk("rst_busy",  busy,  0);
        chk("rst_done",  done,  0);
        reset = 1'b0;
        step();

        // Full 30-second phase, ticks spaced 5 cycles apart
        do_load(6'd30);
        chk("p30_count", count, 30);
        chk("p30_tens",  tens,  3);
        chk("p30_units", units, 0);
        chk("p30_busy",  busy,  1);
        done_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            do_tick();
            if (done) done_cycles++;
            if (i == 28) chk("p30_cnt_before_last", count, 1);
            if (i == 29) chk("p30_done_on_30th", done, 1);
            for (int k = 0; k < 4; k++) begin
                step();
                if (done) done_cycles++;
            end
        end
        chk("p30_done_cycles", done_cycles, 1);
        chk("p30_final_count", count, 0);
        chk("p30_final_busy",  busy,  0);
        chk("p30_state_done",  dut.r_state, 3);

        // Hold freezes the count; expiry on 3rd tick after release
        do_load(6'd5);
        do_tick();
        do_tick();
        chk("h_count_pre", count, 3);
        hold = 1'b1;
        step();
        chk("h_busy", busy, 1);
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            do_tick();
            if (count != 6'd3 || done) hold_bad++;
        end
        chk("h_frozen_violations", hold_bad, 0);
        chk("h_count_held", count, 3);
        hold = 1'b0;
        step();
        do_tick();
        chk("h_rel_t1_count", count, 2);
        chk("h_rel_t1_done",  done,  0);
        do_tick();
        chk("h_rel_t2_done",  done,  0);
        do_tick();
        chk("h_rel_t3_done",  done,  1);
        chk("h_rel_t3_count", count, 0);
        step();
        chk("h_done_fall",    done,  0);

        // Load coincident with tick: tick discarded
        tick = 1'b1;
        do_load(6'd15);
        tick = 1'b0;
        chk("pt_count", count, 15);
        do_tick();
        chk("pt_next", count, 14);
        chk("pt_tens",  tens,  1);
        chk("pt_units", units, 4);

        // Count down to 9, then reload with 22
        for (int i = 0; i < 5; i++) do_tick();
        chk("rl_count9", count, 9);
        chk("rl_units9", units, 9);
        do_load(6'd22);
        chk("rl_count", count, 22);
        chk("rl_tens",  tens,  2);
        chk("rl_units", units, 2);
        chk("rl_done",  done,  0);
        chk("rl_busy",  busy,  1);

        // Asynchronous reset mid-run at count 12
        for (int i = 0; i < 10; i++) do_tick();
        chk("ar_count12", count, 12);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_count", count, 0);
        chk("ar_busy",  busy,  0);
        chk("ar_done",  done,  0);
        chk("ar_tens",  tens,  0);
        chk("ar_units", units, 0);
        reset = 1'b0;
        do_tick();
        do_tick();
        hold = 1'b1;
        do_tick();
        hold = 1'b0;
        chk("ar_post_count", count, 0);
        chk("ar_post_busy",  busy,  0);
        chk("ar_post_state", dut.r_state, 0);

        // Zero preset: immediate single-cycle done, never busy
        do_load(6'd0);
        chk("z_done",  done,  1);
        chk("z_count", count, 0);
        chk("z_busy",  busy,  0);
        chk("z_state", dut.r_state, 3);
        do_tick();
        chk("z_done_fall", done, 0);
        chk("z_busy2",     busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
